// File: rtl/vit_pkg.sv
// Shared types and helpers for the Viterbi decoder frame scheduler.
package vit_pkg;

    localparam int N_STEPS_DEF = 8;
    localparam int SYM_W_DEF   = 2;
    localparam int MAX_IN_W    = 256;
    localparam int MAX_SYM_W   = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        BM   = 3'd1,
        ACS  = 3'd2,
        WR   = 3'd3,
        TB   = 3'd4,
        OUT  = 3'd5
    } state_t;

    // Step k symbol is taken MSB-first: frame[in_w-1-sym_w*k -: sym_w].
    function automatic logic [MAX_SYM_W-1:0] sym_slice(input logic [MAX_IN_W-1:0] frame,
                                                       input int in_w,
                                                       input int sym_w,
                                                       input int k);
        logic [MAX_IN_W-1:0]  shifted;
        logic [MAX_SYM_W-1:0] mask;
        shifted = frame >> (in_w - sym_w * (k + 1));
        mask    = (MAX_SYM_W'(1) << sym_w) - MAX_SYM_W'(1);
        return shifted[MAX_SYM_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/vit_frame_sched.sv
// Frame-level scheduler: sequences BM/ACS/WR per trellis step, then traceback,
// and presents the decoded frame on a valid/ready output.
module vit_frame_sched
    import vit_pkg::*;
#(
    parameter int N_STEPS = N_STEPS_DEF,
    parameter int SYM_W   = SYM_W_DEF,
    localparam int IN_W   = N_STEPS * SYM_W,
    localparam int IDX_W  = $clog2(N_STEPS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    in_data,
    input  logic               flush,
    output logic [SYM_W-1:0]   sym,
    output logic [IDX_W-1:0]   step_idx,
    output logic               pm_clr,
    output logic               en_brch,
    output logic               en_add,
    output logic               en_mem,
    output logic               en_tbck,
    output logic [IDX_W-1:0]   tb_idx,
    input  logic               tb_bit,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N_STEPS-1:0] out_data,
    output logic               busy,
    output state_t             state_dbg
);

    // Handshakes: a transfer happens on the rising edge where valid && ready;
    // valid never waits on ready, and the sender holds its data until the transfer.

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_STEPS - 1);

    state_t           state, nxt_state;
    logic [IDX_W-1:0] cnt;
    logic [IN_W-1:0]  frame_q;
    logic             in_step;
    logic [MAX_SYM_W-1:0] sym_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state = state;
        if (flush) begin
            nxt_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (in_valid) nxt_state = BM;
                BM:      nxt_state = ACS;
                ACS:     nxt_state = WR;
                WR:      nxt_state = (cnt == LAST_IDX) ? TB : BM;
                TB:      nxt_state = (cnt == '0) ? OUT : TB;
                OUT:     if (out_ready) nxt_state = IDLE;
                default: nxt_state = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        pm_clr    = 1'b0;
        en_brch   = 1'b0;
        en_add    = 1'b0;
        en_mem    = 1'b0;
        en_tbck   = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:    in_ready = 1'b1;
            BM: begin
                en_brch = 1'b1;
                pm_clr  = (cnt == '0);
            end
            ACS:     en_add    = 1'b1;
            WR:      en_mem    = 1'b1;
            TB:      en_tbck   = 1'b1;
            OUT:     out_valid = 1'b1;
            default: ;
        endcase
    end

    // One counter serves both phases: it ends the forward pass at N_STEPS-1,
    // which is exactly where traceback starts counting down.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            frame_q  <= '0;
            out_data <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        frame_q <= in_data;
                        cnt     <= '0;
                    end
                end
                WR: begin
                    if (cnt != LAST_IDX) cnt <= cnt + IDX_W'(1);
                end
                TB: begin
                    out_data[cnt] <= tb_bit;
                    if (cnt != '0) cnt <= cnt - IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_step   = (state == BM) || (state == ACS) || (state == WR);
    assign step_idx  = in_step ? cnt : '0;
    assign tb_idx    = (state == TB) ? cnt : '0;
    assign sym_full  = sym_slice(MAX_IN_W'(frame_q), IN_W, SYM_W, int'(step_idx));
    assign sym       = sym_full[SYM_W-1:0];
    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule
